// File: rtl/dispense_timer.sv
// rtl/dispense_timer.sv - per-ingredient dispense timer with prescaled countdown and pause
module dispense_timer #(
    parameter int CNT_W     = 8,
    parameter int PRE_W     = 16,
    parameter int PRESCALE  = 50000,
    parameter int DUR_AGUA  = 20,
    parameter int DUR_CAFE  = 10,
    parameter int DUR_MILK  = 8,
    parameter int DUR_CHOCO = 6,
    parameter int DUR_AZUC  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_timer,
    input  logic [2:0]       ing_type,
    input  logic             pause,
    output logic             t_expired,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic [2:0]       cur_ing
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             start_q;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       cur_q, cur_d;
    logic             exp_q, exp_d;

    logic             start_acc;
    logic             tick;
    logic [CNT_W-1:0] dur;

    assign start_acc = start_timer & ~start_q;
    assign tick      = (state_q == RUN) && !pause && (pre_q == PRE_W'(PRESCALE - 1));

    always_comb begin
        dur = '0;
        case (ing_type)
            3'b000:  dur = CNT_W'(DUR_AGUA);
            3'b001:  dur = CNT_W'(DUR_CAFE);
            3'b010:  dur = CNT_W'(DUR_MILK);
            3'b011:  dur = CNT_W'(DUR_CHOCO);
            3'b100:  dur = CNT_W'(DUR_AZUC);
            default: dur = '0;
        endcase
    end

    // An accepted start always takes priority, which also covers restart and
    // a start landing on the final tick of the previous dispense.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        rem_d   = rem_q;
        cur_d   = cur_q;
        exp_d   = 1'b0;
        if (start_acc) begin
            cur_d = ing_type;
            pre_d = '0;
            if (dur != '0) begin
                state_d = RUN;
                rem_d   = dur;
            end else begin
                state_d = IDLE;
                rem_d   = '0;
                exp_d   = 1'b1;
            end
        end else if ((state_q == RUN) && !pause) begin
            if (tick) begin
                pre_d = '0;
                if (rem_q <= CNT_W'(1)) begin
                    rem_d   = '0;
                    state_d = IDLE;
                    exp_d   = 1'b1;
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            pre_q   <= '0;
            rem_q   <= '0;
            cur_q   <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_timer;
            pre_q   <= pre_d;
            rem_q   <= rem_d;
            cur_q   <= cur_d;
            exp_q   <= exp_d;
        end
    end

    assign t_expired = exp_q;
    assign busy      = (state_q == RUN);
    assign remaining = rem_q;
    assign cur_ing   = cur_q;

endmodule

// File: tb/tb_dispense_timer.sv
// tb/tb_dispense_timer.sv - directed checks of dispense_timer timing, pause, restart and reset
module tb_dispense_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, pause_a, start_b;
    logic [2:0] ing_a, ing_b;
    logic       exp_a, busy_a, exp_b, busy_b;
    logic [7:0] rem_a, rem_b;
    logic [2:0] cur_a, cur_b;

    int n_chk = 0;
    int n_err = 0;
    int pulses, at_c, keff, kk;

    always #5 clk = ~clk;

    dispense_timer #(.PRESCALE(4), .DUR_AGUA(5)) u_dut_a (
        .clk(clk), .reset(reset), .start_timer(start_a), .ing_type(ing_a),
        .pause(pause_a), .t_expired(exp_a), .busy(busy_a), .remaining(rem_a),
        .cur_ing(cur_a)
    );

    dispense_timer #(.PRESCALE(2)) u_dut_b (
        .clk(clk), .reset(reset), .start_timer(start_b), .ing_type(ing_b),
        .pause(1'b0), .t_expired(exp_b), .busy(busy_b), .remaining(rem_b),
        .cur_ing(cur_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; start_a = 1'b0; pause_a = 1'b0; start_b = 1'b0;
        ing_a = 3'd0; ing_b = 3'd0;
        #3;
        chk("rst_exp", exp_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_rem", rem_a, 0);
        chk("rst_cur", cur_a, 0);
        step;
        reset = 1'b1;
        step;

        // water: 5 units x 4 clocks
        ing_a = 3'd0; start_a = 1'b1; step; start_a = 1'b0;
        chk("agua_busy0", busy_a, 1);
        chk("agua_rem0", rem_a, 5);
        for (int k = 1; k <= 21; k++) begin
            step;
            kk = (k < 20) ? k : 20;
            chk("agua_exp", exp_a, (k == 20) ? 1 : 0);
            chk("agua_rem", rem_a, 5 - kk / 4);
            chk("agua_busy", busy_a, (k < 20) ? 1 : 0);
        end

        // start landing on the final tick wins
        start_a = 1'b1; step; start_a = 1'b0;
        repeat (19) step;
        start_a = 1'b1; step; start_a = 1'b0;
        chk("tie_exp", exp_a, 0);
        chk("tie_rem", rem_a, 5);
        chk("tie_busy", busy_a, 1);
        repeat (19) step;
        chk("tie_exp_pre", exp_a, 0);
        step;
        chk("tie_exp_new", exp_a, 1);
        step;

        // sugar with a 7-cycle pause
        ing_a = 3'd4; start_a = 1'b1; step; start_a = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            step;
            keff = (k <= 5) ? k : (k <= 12) ? 5 : k - 7;
            if (keff > 16) keff = 16;
            chk("pause_exp", exp_a, (k == 23) ? 1 : 0);
            chk("pause_rem", rem_a, 4 - keff / 4);
            chk("pause_busy", busy_a, (k < 23) ? 1 : 0);
            if (k == 5) pause_a = 1'b1;
            if (k == 12) pause_a = 1'b0;
        end

        // unknown code: immediate pulse, no busy
        ing_a = 3'd6; start_a = 1'b1; step; start_a = 1'b0;
        chk("zero_exp", exp_a, 1);
        chk("zero_busy", busy_a, 0);
        chk("zero_cur", cur_a, 6);
        step;
        chk("zero_exp_fall", exp_a, 0);

        // coffee restarted as milk at remaining=3
        ing_a = 3'd1; start_a = 1'b1; step; start_a = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 28; k++) begin
            step;
            if (exp_a) pulses++;
        end
        chk("rst_cafe_rem", rem_a, 3);
        ing_a = 3'd2; start_a = 1'b1; step; start_a = 1'b0;
        chk("restart_rem", rem_a, 8);
        chk("restart_cur", cur_a, 2);
        chk("restart_busy", busy_a, 1);
        at_c = 0;
        for (int j = 1; j <= 33; j++) begin
            step;
            if (exp_a) begin pulses++; at_c = j; end
        end
        chk("restart_pulses", pulses, 1);
        chk("restart_at", at_c, 32);

        // held start on instance b: chocolate 6 x 2 clocks
        ing_b = 3'd3; start_b = 1'b1; step;
        pulses = 0; at_c = 0;
        for (int c = 1; c <= 99; c++) begin
            step;
            if (exp_b) begin pulses++; at_c = c; end
        end
        start_b = 1'b0;
        chk("held_pulses", pulses, 1);
        chk("held_at", at_c, 12);
        chk("held_busy", busy_b, 0);

        // asynchronous reset mid-run
        ing_a = 3'd1; start_a = 1'b1; step; start_a = 1'b0;
        repeat (6) step;
        chk("pre_rst_busy", busy_a, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_exp", exp_a, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_rem", rem_a, 0);
        chk("arst_cur", cur_a, 0);
        #1 reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 50; c++) begin
            step;
            if (exp_a) pulses++;
        end
        chk("post_rst_pulses", pulses, 0);
        chk("post_rst_busy", busy_a, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
